instr_decoder: RTL and testbench

- Decodes the MIPS primary opcode and function field into one-hot instruction-class flags.
- Also produces the pipeline result-latency class (Tnew) for the hazard unit.
- Decode path is purely combinational, so D/E pipeline stages use it in the same cycle.
- A small clocked monitor records illegal encodings for debug and verification.

---
 rtl/instr_decoder_pkg.sv | 42 ++++
 rtl/instr_decoder_mon.sv | 51 +++++
 rtl/instr_decoder.sv | 82 ++++++++
 tb/tb_instr_decoder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_decoder_pkg.sv
// Shared MIPS decode constants: opcodes, function codes and Tnew latency classes.
// Also consumed by the E/M/W pipeline registers for Tnew bookkeeping.
package instr_decoder_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [1:0] T_PC     = 2'd0;
  localparam logic [1:0] T_ALU    = 2'd1;
  localparam logic [1:0] T_DM     = 2'd2;

  typedef struct packed {
    logic addu;
    logic subu;
    logic ori;
    logic lui;
    logic lw;
    logic jal;
    logic sw;
    logic beq;
    logic jr;
  } dec_flags_t;

  // Result latency: ALU ops produce in E, loads in M, everything else produces nothing.
  function automatic logic [1:0] tnew_of(input dec_flags_t f);
    logic [1:0] t;
    t = T_PC;
    if (f.addu || f.subu || f.ori || f.lui) t = T_ALU;
    else if (f.lw)                          t = T_DM;
    return t;
  endfunction

endpackage

// File: rtl/instr_decoder_mon.sv
// Clocked illegal-instruction monitor: sticky flag, saturating count and first offending opcode.
module instr_decoder_mon
  import instr_decoder_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic             illegal,
  input  logic [5:0]       op,
  output logic             illegal_seen,
  output logic [CNT_W-1:0] illegal_cnt,
  output logic [5:0]       first_bad_op
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             seen_q, seen_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       bad_op_q, bad_op_d;

  always_comb begin
    seen_d   = seen_q;
    cnt_d    = cnt_q;
    bad_op_d = bad_op_q;
    if (valid && illegal) begin
      seen_d = 1'b1;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      // Only the very first offender is kept for debug.
      if (!seen_q) bad_op_d = op;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      seen_q   <= 1'b0;
      cnt_q    <= '0;
      bad_op_q <= '0;
    end else begin
      seen_q   <= seen_d;
      cnt_q    <= cnt_d;
      bad_op_q <= bad_op_d;
    end
  end

  assign illegal_seen = seen_q;
  assign illegal_cnt  = cnt_q;
  assign first_bad_op = bad_op_q;

endmodule

// File: rtl/instr_decoder.sv
// Combinational MIPS opcode/function decoder with Tnew class and an illegal-encoding monitor.
// Define INSTR_DECODER_EXT_EN to decode sw/beq/jr; otherwise they are reported as illegal.
module instr_decoder
  import instr_decoder_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  output logic             addu,
  output logic             subu,
  output logic             ori,
  output logic             lui,
  output logic             lw,
  output logic             jal,
  output logic             sw,
  output logic             beq,
  output logic             jr,
  output logic             nop,
  output logic             illegal,
  output logic [1:0]       tnew,
  output logic             illegal_seen,
  output logic [CNT_W-1:0] illegal_cnt,
  output logic [5:0]       first_bad_op
);

  dec_flags_t flags;
  logic       rtype;

  assign rtype = (op == OP_RTYPE);

  always_comb begin
    flags      = '0;
    flags.addu = rtype && (func == FN_ADDU);
    flags.subu = rtype && (func == FN_SUBU);
    flags.ori  = (op == OP_ORI);
    flags.lui  = (op == OP_LUI);
    flags.lw   = (op == OP_LW);
    flags.jal  = (op == OP_JAL);
`ifdef INSTR_DECODER_EXT_EN
    flags.sw   = (op == OP_SW);
    flags.beq  = (op == OP_BEQ);
    flags.jr   = rtype && (func == FN_JR);
`else
    flags.sw   = 1'b0;
    flags.beq  = 1'b0;
    flags.jr   = 1'b0;
`endif
  end

  assign addu    = flags.addu;
  assign subu    = flags.subu;
  assign ori     = flags.ori;
  assign lui     = flags.lui;
  assign lw      = flags.lw;
  assign jal     = flags.jal;
  assign sw      = flags.sw;
  assign beq     = flags.beq;
  assign jr      = flags.jr;

  // All-zero word is the pipeline bubble, never an illegal instruction.
  assign nop     = rtype && (func == 6'd0);
  assign illegal = !(|flags) && !nop;
  assign tnew    = tnew_of(flags);

  instr_decoder_mon #(
    .CNT_W(CNT_W)
  ) u_mon (
    .clk          (clk),
    .reset        (reset),
    .valid        (valid),
    .illegal      (illegal),
    .op           (op),
    .illegal_seen (illegal_seen),
    .illegal_cnt  (illegal_cnt),
    .first_bad_op (first_bad_op)
  );

endmodule

// File: tb/tb_instr_decoder.sv
// Randomized self-checking bench for instr_decoder against a table-driven reference model.
module tb_instr_decoder;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef INSTR_DECODER_EXT_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       valid = 1'b0;
  logic [5:0] op = 6'd0;
  logic [5:0] func = 6'd0;
  logic addu, subu, ori, lui, lw, jal, sw, beq, jr, nop, illegal;
  logic [1:0]       tnew;
  logic             illegal_seen;
  logic [CNT_W-1:0] illegal_cnt;
  logic [5:0]       first_bad_op;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  instr_decoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .valid(valid), .op(op), .func(func),
    .addu(addu), .subu(subu), .ori(ori), .lui(lui), .lw(lw), .jal(jal),
    .sw(sw), .beq(beq), .jr(jr), .nop(nop), .illegal(illegal), .tnew(tnew),
    .illegal_seen(illegal_seen), .illegal_cnt(illegal_cnt), .first_bad_op(first_bad_op)
  );

  // Instruction table: flag bit index in {addu,subu,ori,lui,lw,jal,sw,beq,jr} (8..0).
  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    bit         use_fn;
    int         bitpos;
    int         lat;
    bit         ext;
  } ins_t;

  ins_t tbl[9] = '{
    '{6'h00, 6'h21, 1'b1, 8, 1, 1'b0},
    '{6'h00, 6'h23, 1'b1, 7, 1, 1'b0},
    '{6'h0D, 6'h00, 1'b0, 6, 1, 1'b0},
    '{6'h0F, 6'h00, 1'b0, 5, 1, 1'b0},
    '{6'h23, 6'h00, 1'b0, 4, 2, 1'b0},
    '{6'h03, 6'h00, 1'b0, 3, 0, 1'b0},
    '{6'h2B, 6'h00, 1'b0, 2, 0, 1'b1},
    '{6'h04, 6'h00, 1'b0, 1, 0, 1'b1},
    '{6'h00, 6'h08, 1'b1, 0, 0, 1'b1}
  };

  function automatic int lookup(input logic [5:0] o, input logic [5:0] f);
    for (int i = 0; i < 9; i++)
      if ((!tbl[i].ext || EXT) && tbl[i].op == o && (!tbl[i].use_fn || tbl[i].fn == f))
        return i;
    return -1;
  endfunction

  function automatic logic [8:0] m_flags(input logic [5:0] o, input logic [5:0] f);
    int k = lookup(o, f);
    logic [8:0] r = '0;
    if (k >= 0) r[tbl[k].bitpos] = 1'b1;
    return r;
  endfunction

  function automatic int m_tnew(input logic [5:0] o, input logic [5:0] f);
    int k = lookup(o, f);
    return (k >= 0) ? tbl[k].lat : 0;
  endfunction

  function automatic bit m_nop(input logic [5:0] o, input logic [5:0] f);
    return (o == 6'd0) && (f == 6'd0);
  endfunction

  function automatic bit m_illegal(input logic [5:0] o, input logic [5:0] f);
    return (lookup(o, f) < 0) && !m_nop(o, f);
  endfunction

  // Reference monitor state
  bit       m_seen = 1'b0;
  int       m_cnt  = 0;
  logic [5:0] m_fbo = 6'd0;

  always @(posedge clk) begin
    if (!reset) begin
      m_seen <= 1'b0;
      m_cnt  <= 0;
      m_fbo  <= 6'd0;
    end else if (valid && m_illegal(op, func)) begin
      m_seen <= 1'b1;
      m_cnt  <= (m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
      if (!m_seen) m_fbo <= op;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (op=%0h func=%0h)", name, act, exp, op, func);
  endtask

  function automatic logic [8:0] act_flags();
    return {addu, subu, ori, lui, lw, jal, sw, beq, jr};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("flags",   32'(act_flags()),  32'(m_flags(op, func)));
      check("tnew",    32'(tnew),         32'(m_tnew(op, func)));
      check("nop",     32'(nop),          32'(m_nop(op, func)));
      check("illegal", 32'(illegal),      32'(m_illegal(op, func)));
      check("seen",    32'(illegal_seen), 32'(m_seen));
      check("cnt",     32'(illegal_cnt),  32'(m_cnt));
      check("fbo",     32'(first_bad_op), 32'(m_fbo));
    end
  end

  task automatic apply(input logic r, input logic v, input logic [5:0] o, input logic [5:0] f);
    @(posedge clk);
    #1;
    reset = r; valid = v; op = o; func = f;
  endtask

  logic [5:0] sweep_op[6]   = '{6'h00, 6'h00, 6'h0D, 6'h0F, 6'h23, 6'h03};
  logic [5:0] sweep_fn[6]   = '{6'h21, 6'h23, 6'h00, 6'h00, 6'h00, 6'h00};
  logic [8:0] sweep_flg[6]  = '{9'h100, 9'h080, 9'h040, 9'h020, 9'h010, 9'h008};
  logic [1:0] sweep_tnew[6] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd0};

  initial begin
    int exp_cnt;
    apply(1'b0, 1'b0, 6'd0, 6'd0);
    apply(1'b0, 1'b1, 6'h3F, 6'd0);
    apply(1'b1, 1'b0, 6'd0, 6'd0);
    chk_en = 1'b1;
    @(negedge clk);
    $display("reset: seen=%0d cnt=%0d fbo=%0h", illegal_seen, illegal_cnt, first_bad_op);
    check("rst_seen", 32'(illegal_seen), 32'd0);
    check("rst_cnt",  32'(illegal_cnt),  32'd0);
    check("rst_fbo",  32'(first_bad_op), 32'd0);

    for (int i = 0; i < 6; i++) begin
      apply(1'b1, 1'b1, sweep_op[i], sweep_fn[i]);
      @(negedge clk);
      $display("legal op=%0h func=%0h flags=%b tnew=%0d", op, func, act_flags(), tnew);
      check("sweep_flags", 32'(act_flags()), 32'(sweep_flg[i]));
      check("sweep_tnew",  32'(tnew),        32'(sweep_tnew[i]));
      check("sweep_cnt",   32'(illegal_cnt), 32'd0);
    end

    apply(1'b1, 1'b1, 6'd0, 6'd0);
    @(negedge clk);
    $display("bubble: nop=%0d illegal=%0d tnew=%0d", nop, illegal, tnew);
    check("bubble_nop", 32'(nop),     32'd1);
    check("bubble_ill", 32'(illegal), 32'd0);
    check("bubble_tn",  32'(tnew),    32'd0);

    apply(1'b1, 1'b1, 6'h3F, 6'd0);
    @(negedge clk);
    check("cap_ill", 32'(illegal), 32'd1);
    apply(1'b1, 1'b1, 6'h3E, 6'd0);
    @(negedge clk);
    $display("capture1: seen=%0d cnt=%0d fbo=%0h", illegal_seen, illegal_cnt, first_bad_op);
    check("cap_seen", 32'(illegal_seen), 32'd1);
    check("cap_cnt1", 32'(illegal_cnt),  32'd1);
    check("cap_fbo1", 32'(first_bad_op), 32'h3F);
    apply(1'b1, 1'b0, 6'h3F, 6'd0);
    @(negedge clk);
    check("cap_cnt2", 32'(illegal_cnt),  32'd2);
    check("cap_fbo2", 32'(first_bad_op), 32'h3F);
    apply(1'b1, 1'b0, 6'd0, 6'd0);
    @(negedge clk);
    $display("capture2: cnt=%0d fbo=%0h", illegal_cnt, first_bad_op);
    check("cap_hold", 32'(illegal_cnt), 32'd2);

    apply(1'b1, 1'b1, 6'h2B, 6'd0);
    @(negedge clk);
    check("ext_sw",      32'(sw),      32'(EXT));
    check("ext_sw_ill",  32'(illegal), 32'(!EXT));
    apply(1'b1, 1'b1, 6'h04, 6'd0);
    @(negedge clk);
    check("ext_beq",     32'(beq),     32'(EXT));
    check("ext_beq_ill", 32'(illegal), 32'(!EXT));
    apply(1'b1, 1'b1, 6'h00, 6'h08);
    @(negedge clk);
    check("ext_jr",      32'(jr),      32'(EXT));
    check("ext_jr_ill",  32'(illegal), 32'(!EXT));
    check("ext_jr_tn",   32'(tnew),    32'd0);
    apply(1'b1, 1'b0, 6'd0, 6'd0);
    @(negedge clk);
    exp_cnt = EXT ? 2 : 5;
    $display("ext build=%0d: cnt=%0d", EXT, illegal_cnt);
    check("ext_cnt", 32'(illegal_cnt), 32'(exp_cnt));

    for (int i = 0; i < 300; i++) apply(1'b1, 1'b1, 6'h3F, 6'h15);
    apply(1'b1, 1'b1, 6'h3E, 6'd0);
    @(negedge clk);
    $display("saturate: cnt=%0d", illegal_cnt);
    check("sat_cnt", 32'(illegal_cnt), 32'd255);
    apply(1'b0, 1'b1, 6'h3F, 6'd0);
    apply(1'b1, 1'b0, 6'd0, 6'd0);
    @(negedge clk);
    $display("mid-burst reset: seen=%0d cnt=%0d", illegal_seen, illegal_cnt);
    check("sat_rst_cnt",  32'(illegal_cnt),  32'd0);
    check("sat_rst_seen", 32'(illegal_seen), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      logic [5:0] o, f;
      int sel, k;
      sel = $urandom_range(0, 3);
      o = 6'($urandom);
      f = 6'($urandom);
      if (sel == 0) begin
        k = $urandom_range(0, 8);
        o = tbl[k].op;
        f = tbl[k].use_fn ? tbl[k].fn : f;
      end else if (sel == 1) begin
        o = 6'd0;
        if ($urandom_range(0, 1) == 1) f = 6'd0;
      end
      apply(($urandom_range(0, 99) != 0), 1'($urandom_range(0, 1)), o, f);
    end
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
